issue_queue_integer: RTL

- Integer-pipe issue queue: the receiving end of the dispatch decoder's integer dispatch path.
- Accepts dispatch_en_integer with dispatch_opcode plus renamed operand tags/data, and holds entries until both operands are ready.
- Wakes up waiting operands from CDB broadcasts, then issues the oldest ready entry to the integer ALU through a registered valid/ready output stage.
- Drives issueque_full_integer back to the decoder.

---
 rtl/issue_queue_integer.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/issue_queue_integer.sv
// -----------------------------------------------------------------------------
// issue_queue_integer
//
// Integer-pipe issue queue. Entries from the dispatch decoder wait here until
// both source operands are ready. The queue wakes them up from CDB broadcasts
// and sends the oldest ready entry to the integer ALU through a registered
// valid/ready issue stage.
//
// Storage is a collapsing queue. Slot 0 is the oldest entry, and slots
// 0..count-1 are occupied. When an entry issues, every slot above it shifts
// down by one.
//
// Ports:
//   clk, rst_n               clock (rising edge), async active-low reset
//   dispatch_en_integer      write one new entry this cycle
//   dispatch_opcode/rd_tag   opcode and destination tag of the new entry
//   dispatch_rs{1,2}_*       source tag / ready flag / data of the new entry
//   cdb_valid/tag/data       result broadcast used for wakeup and bypass
//   issue_ready              ALU accepts the issue register this cycle
//   issue_valid/opcode/...   registered issue stage towards the ALU
//   issueque_full_integer    queue holds DEPTH entries (back to the decoder)
// -----------------------------------------------------------------------------
module issue_queue_integer #(
    parameter int DEPTH  = 4,
    parameter int TAG_W  = 6,
    parameter int DATA_W = 32,
    parameter int OPC_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              dispatch_en_integer,
    input  logic [OPC_W-1:0]  dispatch_opcode,
    input  logic [TAG_W-1:0]  dispatch_rd_tag,
    input  logic [TAG_W-1:0]  dispatch_rs1_tag,
    input  logic              dispatch_rs1_ready,
    input  logic [DATA_W-1:0] dispatch_rs1_data,
    input  logic [TAG_W-1:0]  dispatch_rs2_tag,
    input  logic              dispatch_rs2_ready,
    input  logic [DATA_W-1:0] dispatch_rs2_data,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_data,
    input  logic              issue_ready,
    output logic              issue_valid,
    output logic [OPC_W-1:0]  issue_opcode,
    output logic [DATA_W-1:0] issue_rs1_data,
    output logic [DATA_W-1:0] issue_rs2_data,
    output logic [TAG_W-1:0]  issue_rd_tag,
    output logic              issueque_full_integer
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [OPC_W-1:0]  opcode;
        logic [TAG_W-1:0]  rd_tag;
        logic [TAG_W-1:0]  rs1_tag;
        logic              rs1_ready;
        logic [DATA_W-1:0] rs1_data;
        logic [TAG_W-1:0]  rs2_tag;
        logic              rs2_ready;
        logic [DATA_W-1:0] rs2_data;
    } entry_t;

    entry_t           slot      [DEPTH];
    entry_t           woken     [DEPTH];
    entry_t           slot_next [DEPTH];
    entry_t           new_entry;
    entry_t           sel_entry;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic [CNT_W-1:0] wr_idx;
    logic [CNT_W-1:0] sel_idx;
    logic             sel_found;
    logic             full;
    logic             advance;
    logic             do_issue;
    logic             do_disp;

    // The full flag depends only on the registered count. It takes no credit
    // for an issue in the same cycle, so it can report full one cycle early.
    assign full                  = (count == CNT_W'(DEPTH));
    assign issueque_full_integer = full;
    assign advance               = !issue_valid || issue_ready;
    assign do_disp               = dispatch_en_integer && !full;
    assign do_issue              = advance && sel_found;

    // Select uses only the registered ready flags, so a wakeup becomes
    // selectable one cycle later. The loop scans downwards so that the
    // lowest (oldest) ready slot is the one that wins.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        sel_entry = slot[0];
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (CNT_W'(i) < count && slot[i].rs1_ready && slot[i].rs2_ready) begin
                sel_found = 1'b1;
                sel_idx   = CNT_W'(i);
                sel_entry = slot[i];
            end
        end
    end

    // Build the incoming entry. A source that is not ready but matches the
    // CDB broadcast in the same cycle is stored as ready with the CDB data.
    // Without this bypass the entry would miss that broadcast and wait forever.
    always_comb begin
        new_entry.opcode    = dispatch_opcode;
        new_entry.rd_tag    = dispatch_rd_tag;
        new_entry.rs1_tag   = dispatch_rs1_tag;
        new_entry.rs1_ready = dispatch_rs1_ready;
        new_entry.rs1_data  = dispatch_rs1_data;
        new_entry.rs2_tag   = dispatch_rs2_tag;
        new_entry.rs2_ready = dispatch_rs2_ready;
        new_entry.rs2_data  = dispatch_rs2_data;
        if (cdb_valid && !dispatch_rs1_ready && dispatch_rs1_tag == cdb_tag) begin
            new_entry.rs1_ready = 1'b1;
            new_entry.rs1_data  = cdb_data;
        end
        if (cdb_valid && !dispatch_rs2_ready && dispatch_rs2_tag == cdb_tag) begin
            new_entry.rs2_ready = 1'b1;
            new_entry.rs2_data  = cdb_data;
        end
    end

    // Apply the wakeup before compaction. An entry that captures CDB data in
    // the same cycle it shifts down then carries that data into its new slot.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            woken[i] = slot[i];
            if (cdb_valid && CNT_W'(i) < count) begin
                if (!slot[i].rs1_ready && slot[i].rs1_tag == cdb_tag) begin
                    woken[i].rs1_ready = 1'b1;
                    woken[i].rs1_data  = cdb_data;
                end
                if (!slot[i].rs2_ready && slot[i].rs2_tag == cdb_tag) begin
                    woken[i].rs2_ready = 1'b1;
                    woken[i].rs2_data  = cdb_data;
                end
            end
        end
    end

    // Compact the queue above the issued slot. The new entry is then written
    // just past the last surviving entry, so it lands at count-1 when an entry
    // leaves in the same cycle and at count otherwise.
    always_comb begin
        wr_idx     = count - CNT_W'(do_issue);
        count_next = count + CNT_W'(do_disp) - CNT_W'(do_issue);
        for (int i = 0; i < DEPTH; i++) begin
            slot_next[i] = woken[i];
        end
        for (int i = 0; i < DEPTH - 1; i++) begin
            if (do_issue && CNT_W'(i) >= sel_idx) begin
                slot_next[i] = woken[i + 1];
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (do_disp && CNT_W'(i) == wr_idx) begin
                slot_next[i] = new_entry;
            end
        end
    end

    // Queue storage and occupancy count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                slot[i] <= '0;
            end
        end else begin
            count <= count_next;
            for (int i = 0; i < DEPTH; i++) begin
                slot[i] <= slot_next[i];
            end
        end
    end

    // Issue register. It refills whenever it is empty or being accepted. If
    // nothing is ready at that point, the valid bit drops and the stale data
    // is left in place.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_valid    <= 1'b0;
            issue_opcode   <= '0;
            issue_rs1_data <= '0;
            issue_rs2_data <= '0;
            issue_rd_tag   <= '0;
        end else if (advance) begin
            issue_valid <= sel_found;
            if (sel_found) begin
                issue_opcode   <= sel_entry.opcode;
                issue_rs1_data <= sel_entry.rs1_data;
                issue_rs2_data <= sel_entry.rs2_data;
                issue_rd_tag   <= sel_entry.rd_tag;
            end
        end
    end

endmodule
